// File: rtl/seq_divider16_8.sv
// Unsigned 16/8 restoring divider, one quotient bit per clock behind start/busy/done.
// Latency 17 cycles from accepted start to done (1 cycle for a zero divisor); start is ignored while busy.
module seq_divider16_8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        last_iter;

    // Partial remainder kept to 8 bits: after every iteration it is below the divisor.
    logic [7:0]  r;
    logic [15:0] q;
    logic [7:0]  d;
    logic [3:0]  cnt;

    logic [8:0]  t;
    logic        ge;
    logic [7:0]  r_nxt;
    logic [15:0] q_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (divisor == 8'd0) ? S_DONE : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == 4'd15) begin
                    last_iter = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // When T >= D the difference is below D, so the low 8 bits of the subtraction suffice.
    always_comb begin
        t     = {r, q[15]};
        ge    = (t >= {1'b0, d});
        r_nxt = ge ? (t[7:0] - d) : t[7:0];
        q_nxt = {q[14:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r         <= 8'd0;
            q         <= 16'd0;
            d         <= 8'd0;
            cnt       <= 4'd0;
            quotient  <= 16'd0;
            remainder <= 8'd0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            r   <= 8'd0;
            q   <= dividend;
            d   <= divisor;
            cnt <= 4'd0;
            if (divisor == 8'd0) begin
                quotient  <= 16'hFFFF;
                remainder <= dividend[7:0];
                div_zero  <= 1'b1;
            end
        end else if (busy) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt + 4'd1;
            if (last_iter) begin
                quotient  <= q_nxt;
                remainder <= r_nxt;
                div_zero  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider16_8.sv
// Directed and randomized checks of seq_divider16_8 against plain-arithmetic division.
module tb_seq_divider16_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int cmp_cnt = 0;
    int err_cnt = 0;

    seq_divider16_8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the first cycle after acceptance; returns positioned in the done cycle.
    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat, output int bc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        wait_done(1, lat, bc);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                                input int lat, input int bc, input bit chk_busy);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        if (b == 8'd0) begin
            eq = 16'hFFFF;
            er = a[7:0];
            ez = 1'b1;
        end else begin
            eq = a / {8'd0, b};
            er = 8'(a % {8'd0, b});
            ez = 1'b0;
        end
        check({tag, ".latency"}, lat, (b == 8'd0) ? 1 : 17);
        if (chk_busy) check({tag, ".busy_cycles"}, bc, (b == 8'd0) ? 0 : 16);
        check({tag, ".quotient"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, ".remainder"}, {24'd0, remainder}, {24'd0, er});
        check({tag, ".div_zero"}, {31'd0, div_zero}, {31'd0, ez});
        if (b != 8'd0) begin
            check({tag, ".invariant"}, {16'd0, quotient} * {24'd0, b} + {24'd0, remainder}, {16'd0, a});
            check({tag, ".rem_lt_div"}, {31'd0, remainder < b}, 32'd1);
        end
    endtask

    initial begin
        int lat;
        int bc;
        int seen;
        logic [15:0] ra;
        logic [7:0]  rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        @(negedge clk);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.quotient", {16'd0, quotient}, 32'd0);
        check("reset.remainder", {24'd0, remainder}, 32'd0);
        check("reset.div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(16'd1000, 8'd7, lat, bc);
        check_result("d1000_7", 16'd1000, 8'd7, lat, bc, 1'b1);
        check("d1000_7.q_abs", {16'd0, quotient}, 32'h008E);
        @(negedge clk);
        check("d1000_7.done_pulse", {31'd0, done}, 32'd0);
        check("d1000_7.held_q", {16'd0, quotient}, 32'h008E);

        do_op(16'hFFFF, 8'hFF, lat, bc);
        check_result("dFFFF_FF", 16'hFFFF, 8'hFF, lat, bc, 1'b1);
        do_op(16'hFFFF, 8'd1, lat, bc);
        check_result("dFFFF_1", 16'hFFFF, 8'd1, lat, bc, 1'b1);
        do_op(16'd5, 8'd10, lat, bc);
        check_result("d5_10", 16'd5, 8'd10, lat, bc, 1'b1);
        do_op(16'd0, 8'd3, lat, bc);
        check_result("d0_3", 16'd0, 8'd3, lat, bc, 1'b1);
        @(negedge clk);

        do_op(16'h1234, 8'd0, lat, bc);
        check_result("d1234_0", 16'h1234, 8'd0, lat, bc, 1'b1);
        @(negedge clk);
        check("d1234_0.done_pulse", {31'd0, done}, 32'd0);
        do_op(16'd9, 8'd2, lat, bc);
        check_result("d9_2", 16'd9, 8'd2, lat, bc, 1'b1);
        @(negedge clk);

        // A start pulse mid-run must be ignored; a start held on done chains immediately.
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start    = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, bc);
        check_result("ign100_3", 16'd100, 8'd3, lat, 0, 1'b0);
        do_op(16'd200, 8'd9, lat, bc);
        check_result("b2b200_9", 16'd200, 8'd9, lat, bc, 1'b1);
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        start    = 1'b1;
        dividend = 16'd300;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.busy", {31'd0, busy}, 32'd0);
        check("arst.done", {31'd0, done}, 32'd0);
        check("arst.quotient", {16'd0, quotient}, 32'd0);
        check("arst.remainder", {24'd0, remainder}, 32'd0);
        check("arst.div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("arst.no_done", seen, 0);
        do_op(16'd77, 8'd7, lat, bc);
        check_result("d77_7", 16'd77, 8'd7, lat, bc, 1'b1);

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_op(ra, rb, lat, bc);
            check_result("rand", ra, rb, lat, bc, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
